// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: turns EX/MEM load/store controls into a registered
// valid/ready data-memory transaction and stalls the pipeline until it completes.
module mem_stage_lsu #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            MemWriteM,
  input  logic [1:0]      ResultSrcM,
  input  logic [XLEN-1:0] ALUResultM,
  input  logic [XLEN-1:0] WriteDataM,
  input  logic [2:0]      funct3M,
  output logic            StallM,
  output logic            ExcM,
  output logic [XLEN-1:0] ReadDataM,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [3:0]      dmem_be,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ready,
  input  logic [XLEN-1:0] dmem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_e;

  state_e          state_q, state_d;
  logic            req_q, req_d;
  logic            we_q, we_d;
  logic [XLEN-1:0] addr_q, addr_d;
  logic [3:0]      be_q, be_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [XLEN-1:0] rdata_q, rdata_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      off_q, off_d;

  logic            is_store, is_load, access, legal, misal, bad;
  logic [1:0]      off;
  logic [3:0]      be_new;
  logic [XLEN-1:0] wdata_new;
  logic [7:0]      lbyte;
  logic [15:0]     lhalf;
  logic [XLEN-1:0] load_fmt;

  // MemWriteM wins when both store and load controls are set.
  assign is_store = MemWriteM;
  assign is_load  = ~MemWriteM & (ResultSrcM == 2'b01);
  assign access   = is_store | is_load;
  assign off      = ALUResultM[1:0];

  always_comb begin
    legal = 1'b0;
    case (funct3M)
      3'b000, 3'b001, 3'b010: legal = 1'b1;
      3'b100, 3'b101:         legal = is_load;
      default:                legal = 1'b0;
    endcase
    misal = ((funct3M[1:0] == 2'b01) & off[0]) |
            ((funct3M[1:0] == 2'b10) & (off != 2'b00));
    bad   = ~legal | misal;
  end

  always_comb begin
    be_new    = 4'hF;
    wdata_new = '0;
    case (funct3M[1:0])
      2'b00:   be_new = 4'b0001 << off;
      2'b01:   be_new = 4'b0011 << off;
      default: be_new = 4'hF;
    endcase
    if (is_store) begin
      case (funct3M[1:0])
        2'b00:   wdata_new = {4{WriteDataM[7:0]}};
        2'b01:   wdata_new = {2{WriteDataM[15:0]}};
        default: wdata_new = WriteDataM;
      endcase
    end
  end

  // Width/offset are captured at issue so formatting does not depend on the held EX/MEM inputs.
  always_comb begin
    lbyte    = dmem_rdata[{off_q, 3'b000} +: 8];
    lhalf    = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    load_fmt = dmem_rdata;
    case (f3_q)
      3'b000:  load_fmt = {{(XLEN-8){lbyte[7]}}, lbyte};
      3'b001:  load_fmt = {{(XLEN-16){lhalf[15]}}, lhalf};
      3'b100:  load_fmt = {{(XLEN-8){1'b0}}, lbyte};
      3'b101:  load_fmt = {{(XLEN-16){1'b0}}, lhalf};
      default: load_fmt = dmem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    f3_d    = f3_q;
    off_d   = off_q;
    StallM  = 1'b0;
    ExcM    = 1'b0;
    case (state_q)
      IDLE: begin
        if (access) begin
          if (bad) begin
            ExcM = 1'b1;
          end else begin
            StallM  = 1'b1;
            state_d = REQ;
            req_d   = 1'b1;
            we_d    = is_store;
            addr_d  = {ALUResultM[XLEN-1:2], 2'b00};
            be_d    = be_new;
            wdata_d = wdata_new;
            f3_d    = funct3M;
            off_d   = off;
          end
        end
      end
      REQ: begin
        StallM = 1'b1;
        if (dmem_ready) begin
          req_d   = 1'b0;
          state_d = DONE;
          if (!we_q) rdata_d = load_fmt;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (reset) begin
      StallM = 1'b0;
      ExcM   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      f3_q    <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      f3_q    <= f3_d;
      off_q   <= off_d;
    end
  end

  assign ReadDataM  = rdata_q;
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;

endmodule
